// File: rtl/heat_stencil_core.sv
// Ping-pong 5-point heat-diffusion stencil engine: one cell per clock, raster order,
// with a stable front bank for host readback and the VGA pixel path.
module heat_stencil_core #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 32,
    parameter int DW      = 8,
    parameter int COEFF_W = 8,
    parameter int STEP_W  = 8,
    parameter int AW      = $clog2(GRID_W * GRID_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COEFF_W-1:0] cfg_alpha,
    input  logic [DW-1:0]      cfg_bnd_temp,
    input  logic [1:0]         cfg_bnd_type,
    input  logic               start,
    input  logic [STEP_W-1:0]  n_steps,
    output logic               busy,
    output logic               done,
    output logic [STEP_W-1:0]  step_cnt,
    input  logic               host_wr_en,
    input  logic [AW-1:0]      host_addr,
    input  logic [DW-1:0]      host_wr_data,
    output logic               wr_err,
    output logic [DW-1:0]      host_rd_data,
    input  logic [AW-1:0]      pix_addr,
    output logic [DW-1:0]      pix_data
);

    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int LW    = DW + 3;
    localparam int PW    = LW + COEFF_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    // Both banks share one array; the top address bit selects the bank.
    logic [DW-1:0] mem [0:2*CELLS-1];

    logic [0:0]         state_reg;
    logic               front_reg;
    logic [AW-1:0]      idx_reg;
    logic [STEP_W-1:0]  step_cnt_reg;
    logic [STEP_W-1:0]  n_steps_reg;
    logic [COEFF_W-1:0] alpha_reg;
    logic [DW-1:0]      bnd_temp_reg;
    logic [1:0]         bnd_type_reg;
    logic               done_reg;
    logic               wr_err_reg;
    logic [DW-1:0]      host_rd_reg;
    logic [DW-1:0]      pix_reg;

    logic [XW-1:0] cell_x;
    logic [YW-1:0] cell_y;
    logic          on_top, on_bottom, on_left, on_right, on_edge;
    logic          bnd_neumann, bnd_dirichlet;
    logic [3:0]    nb_out;
    logic [DW-1:0] nb_val [4];
    logic [DW-1:0] c_val;

    assign cell_x    = idx_reg[XW-1:0];
    assign cell_y    = idx_reg[AW-1:XW];
    assign on_top    = (cell_y == '0);
    assign on_bottom = (cell_y == '1);
    assign on_left   = (cell_x == '0);
    assign on_right  = (cell_x == '1);
    assign on_edge   = on_top | on_bottom | on_left | on_right;

    assign bnd_neumann   = (bnd_type_reg == 2'b01);
    assign bnd_dirichlet = (bnd_type_reg == 2'b00) || (bnd_type_reg == 2'b11);

    // Neighbour order: 0 = N, 1 = S, 2 = E, 3 = W.
    assign nb_out = {on_left, on_right, on_bottom, on_top};
    assign c_val  = mem[{front_reg, idx_reg}];

    // Power-of-two dimensions make periodic wrap fall out of the address truncation.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nb
            localparam int DX = (gi == 2) ? 1 : ((gi == 3) ? -1 : 0);
            localparam int DY = (gi == 1) ? 1 : ((gi == 0) ? -1 : 0);
            logic [XW-1:0] nx;
            logic [YW-1:0] ny;
            assign nx = cell_x + XW'(DX);
            assign ny = cell_y + YW'(DY);
            assign nb_val[gi] = (bnd_neumann && nb_out[gi]) ? c_val : mem[{front_reg, ny, nx}];
        end
    endgenerate

    logic [LW-1:0]        nb_sum;
    logic signed [LW-1:0] lap;
    logic signed [PW-1:0] alpha_s, lap_s, prod, delta, new_s;
    logic [DW-1:0]        sat_val;
    logic [DW-1:0]        cell_next;

    assign nb_sum  = LW'(nb_val[0]) + LW'(nb_val[1]) + LW'(nb_val[2]) + LW'(nb_val[3]);
    assign lap     = $signed(nb_sum - {1'b0, c_val, 2'b00});
    assign alpha_s = $signed({{(PW-COEFF_W){1'b0}}, alpha_reg});
    assign lap_s   = {{(PW-LW){lap[LW-1]}}, lap};
    assign prod    = alpha_s * lap_s;
    assign delta   = prod >>> 8;
    assign new_s   = $signed({{(PW-DW){1'b0}}, c_val}) + delta;

    always_comb begin
        sat_val = new_s[DW-1:0];
        if (new_s[PW-1]) begin
            sat_val = '0;
        end else if (|new_s[PW-2:DW]) begin
            sat_val = '1;
        end
        cell_next = (bnd_dirichlet && on_edge) ? bnd_temp_reg : sat_val;
    end

    // Host writes are only accepted while idle, so the sweep owns the write port when busy.
    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign mem_we    = !rst && ((state_reg == SWEEP) || host_wr_en);
    assign mem_waddr = (state_reg == SWEEP) ? {~front_reg, idx_reg} : {front_reg, host_addr};
    assign mem_wdata = (state_reg == SWEEP) ? cell_next : host_wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic               last_cell;
    logic [STEP_W-1:0]  step_cnt_next;

    assign last_cell     = (idx_reg == AW'(CELLS - 1));
    assign step_cnt_next = step_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            front_reg    <= 1'b0;
            idx_reg      <= '0;
            step_cnt_reg <= '0;
            n_steps_reg  <= '0;
            alpha_reg    <= '0;
            bnd_temp_reg <= '0;
            bnd_type_reg <= '0;
            done_reg     <= 1'b0;
            wr_err_reg   <= 1'b0;
            host_rd_reg  <= '0;
            pix_reg      <= '0;
        end else begin
            done_reg    <= 1'b0;
            wr_err_reg  <= host_wr_en && (state_reg == SWEEP);
            host_rd_reg <= mem[{front_reg, host_addr}];
            pix_reg     <= mem[{front_reg, pix_addr}];
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        step_cnt_reg <= '0;
                        if (n_steps != '0) begin
                            alpha_reg    <= cfg_alpha;
                            bnd_temp_reg <= cfg_bnd_temp;
                            bnd_type_reg <= cfg_bnd_type;
                            n_steps_reg  <= n_steps;
                            idx_reg      <= '0;
                            state_reg    <= SWEEP;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (last_cell) begin
                        front_reg    <= ~front_reg;
                        step_cnt_reg <= step_cnt_next;
                        if (step_cnt_next == n_steps_reg) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy         = (state_reg == SWEEP);
    assign done         = done_reg;
    assign step_cnt     = step_cnt_reg;
    assign wr_err       = wr_err_reg;
    assign host_rd_data = host_rd_reg;
    assign pix_data     = pix_reg;

endmodule

// File: tb/tb_heat_stencil_core.sv
// Randomised bench for heat_stencil_core against a cell-by-cell integer model of the grid.
module tb_heat_stencil_core;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int CELLS = W * H;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    cfg_alpha = '0;
    logic [7:0]    cfg_bnd_temp = '0;
    logic [1:0]    cfg_bnd_type = '0;
    logic          start = 1'b0;
    logic [7:0]    n_steps = '0;
    logic          busy, done, wr_err;
    logic [7:0]    step_cnt;
    logic          host_wr_en = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_wr_data = '0;
    logic [7:0]    host_rd_data;
    logic [AW-1:0] pix_addr = '0;
    logic [7:0]    pix_data;

    heat_stencil_core dut (
        .clk(clk), .rst(rst),
        .cfg_alpha(cfg_alpha), .cfg_bnd_temp(cfg_bnd_temp), .cfg_bnd_type(cfg_bnd_type),
        .start(start), .n_steps(n_steps), .busy(busy), .done(done), .step_cnt(step_cnt),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
        .wr_err(wr_err), .host_rd_data(host_rd_data), .pix_addr(pix_addr), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int g  [CELLS];
    int gn [CELLS];
    int m_alpha, m_type, m_temp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int at(int x, int y, int cx, int cy);
        if (x >= 0 && x < W && y >= 0 && y < H) return g[y*W + x];
        if (m_type == 2) return g[((y + H) % H)*W + ((x + W) % W)];
        return g[cy*W + cx];
    endfunction

    task automatic step_model();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int c, lap, prod, dlt, v;
                c = g[y*W + x];
                if ((m_type == 0 || m_type == 3) && (x == 0 || y == 0 || x == W-1 || y == H-1)) begin
                    gn[y*W + x] = m_temp;
                end else begin
                    lap  = at(x, y-1, x, y) + at(x, y+1, x, y) + at(x+1, y, x, y) + at(x-1, y, x, y) - 4*c;
                    prod = m_alpha * lap;
                    dlt  = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
                    v    = c + dlt;
                    gn[y*W + x] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
                end
            end
        end
        for (int i = 0; i < CELLS; i++) g[i] = gn[i];
    endtask

    task automatic load_grid();
        for (int a = 0; a < CELLS; a++) begin
            host_wr_en   = 1'b1;
            host_addr    = a[AW-1:0];
            host_wr_data = g[a][7:0];
            tick();
        end
        host_wr_en = 1'b0;
    endtask

    task automatic verify(input string tag);
        for (int a = 0; a < CELLS; a++) begin
            int b;
            b = CELLS - 1 - a;
            host_addr = a[AW-1:0];
            pix_addr  = b[AW-1:0];
            tick();
            check({tag, "_host"}, host_rd_data, g[a]);
            check({tag, "_pix"}, pix_data, g[b]);
        end
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        int a;
        a = y*W + x;
        host_addr = a[AW-1:0];
        tick();
        v = host_rd_data;
    endtask

    task automatic run_steps(input string tag, input int n, input int alpha, input int btype,
                             input int btemp, input int wr_at, input int st_at, input int co_wr);
        int k, pa, pre_val, limit, ca, cv;
        pa = $urandom_range(0, CELLS-1);
        pix_addr     = pa[AW-1:0];
        cfg_alpha    = alpha[7:0];
        cfg_bnd_type = btype[1:0];
        cfg_bnd_temp = btemp[7:0];
        n_steps      = n[7:0];
        start        = 1'b1;
        if (co_wr != 0) begin
            ca = $urandom_range(W+1, CELLS-W-2);
            cv = $urandom_range(0, 255);
            host_wr_en   = 1'b1;
            host_addr    = ca[AW-1:0];
            host_wr_data = cv[7:0];
            g[ca] = cv;
        end
        m_alpha = alpha; m_type = btype; m_temp = btemp;
        pre_val = g[pa];
        for (int s = 0; s < n; s++) begin
            pre_val = g[pa];
            step_model();
        end
        tick();
        start        = 1'b0;
        host_wr_en   = 1'b0;
        cfg_alpha    = 8'($urandom);
        cfg_bnd_type = 2'($urandom);
        cfg_bnd_temp = 8'($urandom);
        if (n > 0) check({tag, "_busy_on"}, busy, 1);
        limit = n*CELLS + 8;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            if (k == wr_at) begin
                host_wr_en   = 1'b1;
                host_addr    = 10'($urandom);
                host_wr_data = 8'($urandom);
            end
            if (k == st_at) begin
                start   = 1'b1;
                n_steps = 8'($urandom_range(1, 255));
            end
            tick();
            k++;
            if (k == wr_at + 1) begin
                check({tag, "_wr_err"}, wr_err, 1);
                host_wr_en = 1'b0;
            end
            if (k == wr_at + 2) check({tag, "_wr_err_pulse"}, wr_err, 0);
            if (k == st_at + 1) start = 1'b0;
            if (n > 1 && k == CELLS) check({tag, "_step_mid"}, step_cnt, 1);
        end
        check({tag, "_latency"}, k, n*CELLS);
        check({tag, "_done"}, done, 1);
        check({tag, "_step_cnt"}, step_cnt, n);
        check({tag, "_busy_off"}, busy, 0);
        if (n > 0) check({tag, "_pix_preswap"}, pix_data, pre_val);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_pix_post"}, pix_data, g[pa]);
        $display("run %s n=%0d alpha=%0d type=%0d temp=%0d latency=%0d", tag, n, alpha, btype, btemp, k);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < CELLS; i++) g[i] = v;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int v, seen_done;

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_step_cnt", step_cnt, 0);
        check("rst_host_rd", host_rd_data, 0);
        check("rst_pix", pix_data, 0);
        rst = 1'b0;
        tick();

        host_wr_en = 1'b1; host_addr = 10'd5; host_wr_data = 8'hA5;
        tick();
        host_wr_en = 1'b0;
        tick();
        check("raw_read", host_rd_data, 8'hA5);
        check("idle_wr_err", wr_err, 0);
        $display("write addr=5 data=165 readback=%0d", host_rd_data);

        fill(0); g[16*W + 16] = 255;
        load_grid();
        run_steps("dirichlet", 1, 64, 0, 0, -10, -10, 0);
        read_cell(16, 16, v); check("dir_center", v, 0);
        read_cell(17, 16, v); check("dir_e", v, 63);
        read_cell(15, 16, v); check("dir_w", v, 63);
        read_cell(16, 15, v); check("dir_n", v, 63);
        read_cell(16, 17, v); check("dir_s", v, 63);
        read_cell(0, 0, v);   check("dir_corner", v, 0);
        verify("dir_grid");

        run_steps("nsteps0", 0, 64, 0, 0, -10, -10, 0);
        verify("nsteps0_grid");

        fill(0); g[0] = 255;
        load_grid();
        run_steps("periodic", 1, 64, 2, 0, -10, -10, 0);
        read_cell(31, 0, v); check("per_wrap_x", v, 63);
        read_cell(0, 31, v); check("per_wrap_y", v, 63);
        verify("per_grid");

        fill(0); g[0] = 255;
        load_grid();
        run_steps("neumann", 1, 64, 1, 0, -10, -10, 0);
        read_cell(0, 0, v); check("neu_corner", v, 127);
        verify("neu_grid");

        fill(0);
        g[9*W + 10] = 255; g[11*W + 10] = 255; g[10*W + 9] = 255; g[10*W + 11] = 255;
        load_grid();
        run_steps("saturate", 1, 255, 0, 0, -10, -10, 0);
        read_cell(10, 10, v); check("sat_cell", v, 255);
        verify("sat_grid");

        for (int i = 0; i < CELLS; i++) g[i] = $urandom_range(0, 255);
        load_grid();
        run_steps("handshake3", 3, $urandom_range(0, 255), $urandom_range(0, 3),
                  $urandom_range(0, 255), 700, 1500, 1);
        verify("hs3_grid");

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < CELLS; i++) g[i] = $urandom_range(0, 255);
            load_grid();
            run_steps("random", $urandom_range(1, 2), $urandom_range(0, 255), t == 0 ? 3 : $urandom_range(0, 2),
                      $urandom_range(0, 255), $urandom_range(10, 900), -10, t % 2);
            verify("rand_grid");
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < CELLS; i++) g[i] = $urandom_range(0, 255);
        load_grid();
        cfg_alpha = 8'd100; cfg_bnd_type = 2'b10; n_steps = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        seen_done = 0;
        repeat (500) begin
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_step_cnt", step_cnt, 0);
        check("midrst_pix", pix_data, 0);
        rst = 1'b0;
        repeat (30) begin
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        check("midrst_no_done", seen_done, 0);
        check("midrst_busy_after", busy, 0);
        verify("midrst_bank0");
        $display("reset mid-run after 500 cycles done_seen=%0d", seen_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
